// File: rtl/tl45_mul_seq.sv
// tl45_mul_seq: sequential 32x32->64 radix-2 shift-add multiplier for the tl45
// execute stage. It owns no adder. Every cycle it drives the operands and carry-in
// of the shared external 32-bit KSA and consumes that adder's sum and carry-out.
// Optional signed support is compiled in with the macro TL45_MUL_SIGNED_EN.
// Signed operands are multiplied as magnitudes, and the 64-bit result is then
// negated with two extra adder passes.
module tl45_mul_seq (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_signed,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_prod,
    output logic [31:0] o_add_a,
    output logic [31:0] o_add_b,
    output logic        o_add_cin,
    input  logic [31:0] i_add_sum,
    input  logic        i_add_cout
);

`ifdef TL45_MUL_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE, S_NEGA, S_NEGB, S_MUL, S_NEGL, S_NEGH, S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_MUL, S_DONE
    } state_t;
`endif

    state_t      state;
    logic [31:0] mcand;
    logic [31:0] acc;
    logic [31:0] q;
    logic [4:0]  cnt;

`ifdef TL45_MUL_SIGNED_EN
    logic        neg_a;
    logic        neg_b;
    logic        sgn;
    logic        c_lo;
    // Marks a signed op. A signed op takes the negate states even when both
    // operands are positive, which keeps its latency fixed.
    logic        sop;
`else
    logic        unused_signed;
    assign unused_signed = i_signed;
`endif

    // The product is exposed only while it is valid, so the consumer never sees partial sums.
    assign o_prod = o_valid ? {acc, q} : 64'd0;

    // Adder operand mux. The adder inputs are zero whenever the block is not using it.
    always_comb begin
        o_add_a   = 32'd0;
        o_add_b   = 32'd0;
        o_add_cin = 1'b0;
        case (state)
            S_MUL: begin
                o_add_a = acc;
                o_add_b = q[0] ? mcand : 32'd0;
            end
`ifdef TL45_MUL_SIGNED_EN
            S_NEGA: begin
                o_add_a   = ~mcand;
                o_add_cin = 1'b1;
            end
            S_NEGB, S_NEGL: begin
                o_add_a   = ~q;
                o_add_cin = 1'b1;
            end
            S_NEGH: begin
                o_add_a   = ~acc;
                o_add_cin = c_lo;
            end
`endif
            default: ;
        endcase
    end

    // Control FSM and datapath registers. o_ready rises one cycle after IDLE is
    // entered, so the DONE handshake cycle can never double as an accept cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            mcand   <= 32'd0;
            acc     <= 32'd0;
            q       <= 32'd0;
            cnt     <= 5'd0;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
`ifdef TL45_MUL_SIGNED_EN
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            sgn     <= 1'b0;
            c_lo    <= 1'b0;
            sop     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        mcand   <= i_a;
                        q       <= i_b;
                        acc     <= 32'd0;
                        cnt     <= 5'd0;
                        o_ready <= 1'b0;
`ifdef TL45_MUL_SIGNED_EN
                        neg_a   <= i_signed & i_a[31];
                        neg_b   <= i_signed & i_b[31];
                        sgn     <= (i_signed & i_a[31]) ^ (i_signed & i_b[31]);
                        sop     <= i_signed;
                        state   <= i_signed ? S_NEGA : S_MUL;
`else
                        state   <= S_MUL;
`endif
                    end
                end
`ifdef TL45_MUL_SIGNED_EN
                S_NEGA: begin
                    if (neg_a)
                        mcand <= i_add_sum;
                    state <= S_NEGB;
                end
                S_NEGB: begin
                    if (neg_b)
                        q <= i_add_sum;
                    state <= S_MUL;
                end
`endif
                S_MUL: begin
                    // Shift the {cout, sum, q} concatenation right by one bit. The
                    // adder carry becomes acc[31].
                    acc <= {i_add_cout, i_add_sum[31:1]};
                    q   <= {i_add_sum[0], q[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
`ifdef TL45_MUL_SIGNED_EN
                        if (sop) begin
                            state <= S_NEGL;
                        end else begin
                            state   <= S_DONE;
                            o_valid <= 1'b1;
                        end
`else
                        state   <= S_DONE;
                        o_valid <= 1'b1;
`endif
                    end
                end
`ifdef TL45_MUL_SIGNED_EN
                S_NEGL: begin
                    // The carry out of ~lo + 1 is set only when lo is zero. It
                    // carries the +1 into the high word.
                    if (sgn)
                        q <= i_add_sum;
                    c_lo  <= i_add_cout;
                    state <= S_NEGH;
                end
                S_NEGH: begin
                    if (sgn)
                        acc <= i_add_sum;
                    state   <= S_DONE;
                    o_valid <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl45_mul_seq.sv
// Bench for tl45_mul_seq. It provides a behavioural stand-in for the external
// 32-bit adder and checks every product against plain 64-bit arithmetic.
module tb_tl45_mul_seq;

`ifdef TL45_MUL_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_a = 32'd0;
    logic [31:0] i_b = 32'd0;
    logic        i_signed = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [63:0] o_prod;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    always #5 clk = ~clk;

    // External adder stand-in.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    tl45_mul_seq dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_signed   (i_signed),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_prod     (o_prod),
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .o_add_cin  (add_cin),
        .i_add_sum  (add_sum),
        .i_add_cout (add_cout)
    );

    int nvec = 0;
    int nfail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp_u;
        logic [63:0] exp_s;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product computed with plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s && SIGNED_BUILD) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int hold);
        int          lat;
        int          w;
        int          exp_lat;
        bit          saw_ready;
        bit          stable;
        logic [63:0] p0;
        exp_lat = (s && SIGNED_BUILD) ? 37 : 33;
        w = 0;
        while (!o_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        check({name, " ready"}, {63'd0, o_ready}, 64'd1);
        i_a = a;
        i_b = b;
        i_signed = s;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_a = $urandom;
        i_b = $urandom;
        i_signed = 1'($urandom_range(0, 1));
        lat = 1;
        saw_ready = 1'b0;
        while (!o_valid && lat < 100) begin
            saw_ready |= o_ready;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy"}, {63'd0, saw_ready}, 64'd0);
        check({name, " product"}, o_prod, exp);
        p0 = o_prod;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!o_valid || o_prod !== p0)
                stable = 1'b0;
        end
        if (hold > 0)
            check({name, " hold"}, {63'd0, stable}, 64'd1);
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        check({name, " valid drop"}, {63'd0, o_valid}, 64'd0);
        check({name, " no early ready"}, {63'd0, o_ready}, 64'd0);
        @(negedge clk);
        check({name, " ready return"}, {63'd0, o_ready}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        tbl[0] = '{32'd7,         32'd6,         1'b0, 64'h0000_0000_0000_002A, 64'h0000_0000_0000_002A};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001};
        tbl[2] = '{32'hFFFF_FFFD, 32'd5,         1'b1, 64'h0000_0004_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
        tbl[4] = '{32'd0,         32'hFFFF_FFFF, 1'b1, 64'd0,                   64'd0};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001};
        tbl[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h7FFF_FFFE_8000_0001, 64'hFFFF_FFFF_8000_0001};
        tbl[7] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000};
        tbl[8] = '{32'h8000_0000, 32'd1,         1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000};
        tbl[9] = '{32'h1234_5678, 32'd0,         1'b0, 64'd0,                   64'd0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset ready", {63'd0, o_ready}, 64'd0);
        check("reset valid", {63'd0, o_valid}, 64'd0);
        check("reset prod", o_prod, 64'd0);
        check("reset adder", {add_a, add_b}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release ready", {63'd0, o_ready}, 64'd1);
        check("idle adder ab", {add_a, add_b}, 64'd0);
        check("idle adder cin", {63'd0, add_cin}, 64'd0);

        // Table vectors
        for (int i = 0; i < 10; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].s,
                   SIGNED_BUILD ? tbl[i].exp_s : tbl[i].exp_u, i % 3);

        // Backpressure in DONE for 10 cycles
        run_op("backpressure", 32'd7, 32'd6, 1'b0, 64'h2A, 10);

        // Adder port behaviour in MUL, then a reset abort at cnt=10
        i_a = 32'd7;
        i_b = 32'd6;
        i_signed = 1'b0;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        check("mul q0=0 add_b", {32'd0, add_b}, 64'd0);
        check("mul q0=0 cin", {63'd0, add_cin}, 64'd0);
        check("mul first add_a", {32'd0, add_a}, 64'd0);
        @(negedge clk);
        check("mul q0=1 add_b", {32'd0, add_b}, 64'd7);
        check("mul q0=1 cin", {63'd0, add_cin}, 64'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort valid", {63'd0, o_valid}, 64'd0);
        check("abort prod", o_prod, 64'd0);
        check("abort ready", {63'd0, o_ready}, 64'd0);
        check("abort adder", {add_a, add_b}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort release ready", {63'd0, o_ready}, 64'd1);
        run_op("after abort", 32'd2, 32'd3, 1'b0, 64'd6, 0);

        // Randomized ops against the reference model
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), i % 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
